dilated_tap_mac: RTL
====================

DILATED_TAP_MAC -- requirements
Module: dilated_tap_mac

Interface
REQ-001 Parameter: W, default 16, element width in bits for taps, weights, bias and result.
REQ-002 Parameter: FRAC, default 12, number of fractional bits (Q(W-FRAC).FRAC fixed point).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset; asynchronous, active-low.
REQ-005 Port: in_valid  input  1  tap/weight set presented.
REQ-006 Port: in_ready  output  1  block can accept a set.
REQ-007 Port: x_0, x_1, x_2, x_3  input  W each, signed  taps t_-3, t_-2, t_-1, t_0 from the upstream 4-entry shift buffer.
REQ-008 Port: w_0, w_1, w_2, w_3  input  W each, signed  kernel weights, paired index-for-index with x_0..x_3.
REQ-009 Port: bias  input  W, signed  additive bias, same Q format.
REQ-010 Port: out_valid  output  1  result available.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: out  output  W, signed  saturated, rounded result.

Function
REQ-013 The block SHALL compute out = sat(round((bias<<FRAC + sum_i x_i*w_i) >> FRAC)), using one multiplier time-shared over 4 cycles.
REQ-014 The accumulator SHALL be signed, 2W+3 bits wide, so no intermediate overflow is possible.
REQ-015 The FSM SHALL have exactly three states: IDLE, MAC, OUT.
REQ-016 IDLE: in_ready=1, out_valid=0.
  - On in_valid=1, register x_0..x_3, w_0..w_3 and bias.
  - Load accumulator with bias<<FRAC (sign-extended); tap index := 0; go to MAC.
REQ-017 MAC: in_ready=0.
  - Each cycle: accumulator += x[idx]*w[idx] (full 2W-bit signed product); idx increments.
  - After idx=3 is accumulated, register the final result into out and go to OUT.
REQ-018 Rounding: add 2^(FRAC-1), then arithmetic shift right by FRAC (round half toward +infinity).
REQ-019 Saturation: clamp the rounded value to [-2^(W-1), 2^(W-1)-1].
REQ-020 OUT: out_valid=1, in_ready=0.
  - out SHALL remain stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE.
REQ-021 Latency: input handshake on edge E; out_valid SHALL be high in the cycle after edge E+4 (5 edges later).
REQ-022 Throughput: one result per 6 cycles minimum when out_ready is held at 1.
REQ-023 in_valid SHALL be ignored outside IDLE; inputs may change freely after capture without affecting the result.
REQ-024 out SHALL retain its last value after the OUT handshake until the next result is registered.

Reset
REQ-025 rst=0 SHALL asynchronously force: state IDLE, out=0, out_valid=0, accumulator=0, idx=0, all captured registers=0.
REQ-026 in_ready SHALL read 0 while rst=0 and 1 from the first cycle after release.
REQ-027 Reset asserted during MAC or OUT SHALL abort the operation with no result emitted.

Verification
REQ-028 Unity: x=4096 all, w=1024 all, bias=0, out_ready=1 -> out=4096, out_valid high 5 edges after capture for 1 cycle.
REQ-029 Rounding:
  - x_0=1, w_0=2048, other taps 0, bias=0 -> out=1.
  - Same with w_0=2047 -> out=0.
  - x_0=-1, w_0=2048 -> out=0.
REQ-030 Saturation:
  - x=32767 all, w=32767 all, bias=32767 -> out=32767.
  - x=32767 all, w=-32768 all, bias=0 -> out=-32768.
REQ-031 Backpressure: out_ready=0 for 3 cycles in OUT -> out and out_valid held stable, in_ready=0, a concurrent in_valid pulse is dropped; out_ready=1 -> IDLE next cycle.
REQ-032 Reset mid-MAC: rst=0 in the 2nd MAC cycle -> out=0, out_valid=0 immediately; the next set after release yields its correct value only.
REQ-033 Back-to-back: in_valid held high with 3 distinct sets, out_ready=1 -> 3 correct results spaced exactly 6 cycles apart.

Source files
------------

// File: rtl/dilated_tap_mac.sv
// dilated_tap_mac: four-tap fixed-point dot product with a bias term.
// One signed multiplier is time-shared over four cycles. The result is
// rounded half toward +infinity and saturated to W bits.
//
// Handshake rules (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. in_ready is high only in IDLE, so
// in_valid is ignored at all other times. out_valid is high only in OUT.
// While out_valid=1 and out_ready=0, out does not change.
module dilated_tap_mac #(
  parameter int W    = 16,
  parameter int FRAC = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] x_0,
  input  logic signed [W-1:0] x_1,
  input  logic signed [W-1:0] x_2,
  input  logic signed [W-1:0] x_3,
  input  logic signed [W-1:0] w_0,
  input  logic signed [W-1:0] w_1,
  input  logic signed [W-1:0] w_2,
  input  logic signed [W-1:0] w_3,
  input  logic signed [W-1:0] bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out,
  output logic [1:0]          o_dbg_state
);

  // The accumulator holds the bias and four full products with headroom,
  // so no intermediate sum can overflow.
  localparam int AW = 2 * W + 3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  // The constants below are one bit wider than the accumulator, so adding
  // the rounding constant cannot wrap.
  localparam logic signed [AW:0] HALF = (AW + 1)'(1) << (FRAC - 1);
  localparam logic signed [AW:0] MAXV = {{(AW + 2 - W){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AW:0] MINV = {{(AW + 2 - W){1'b1}}, {(W - 1){1'b0}}};

  logic [1:0]          r_state;
  logic signed [W-1:0] r_x [4];
  logic signed [W-1:0] r_w [4];
  logic signed [AW-1:0] r_acc;
  logic [1:0]          r_idx;
  logic signed [W-1:0] r_out;

  logic signed [2*W-1:0] w_xe;
  logic signed [2*W-1:0] w_we;
  logic signed [2*W-1:0] w_prod;
  logic signed [AW-1:0]  w_acc_next;
  logic signed [AW:0]    w_rnd;
  logic signed [AW:0]    w_shift;
  logic signed [W-1:0]   w_sat;

  // Datapath: product of the current tap pair, the running sum, and the
  // round-and-saturate step applied to that sum.
  always_comb begin
    w_xe       = {{W{r_x[r_idx][W-1]}}, r_x[r_idx]};
    w_we       = {{W{r_w[r_idx][W-1]}}, r_w[r_idx]};
    w_prod     = w_xe * w_we;
    w_acc_next = r_acc + {{(AW - 2 * W){w_prod[2*W-1]}}, w_prod};
    w_rnd      = {w_acc_next[AW-1], w_acc_next} + HALF;
    w_shift    = w_rnd >>> FRAC;
    if (w_shift > MAXV) begin
      w_sat = {1'b0, {(W - 1){1'b1}}};
    end else if (w_shift < MINV) begin
      w_sat = {1'b1, {(W - 1){1'b0}}};
    end else begin
      w_sat = w_shift[W-1:0];
    end
  end

  // Control FSM: capture in IDLE, four accumulate cycles in MAC, hold the result in OUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_idx   <= '0;
      r_out   <= '0;
      for (int i = 0; i < 4; i++) begin
        r_x[i] <= '0;
        r_w[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x[0] <= x_0;
            r_x[1] <= x_1;
            r_x[2] <= x_2;
            r_x[3] <= x_3;
            r_w[0] <= w_0;
            r_w[1] <= w_1;
            r_w[2] <= w_2;
            r_w[3] <= w_3;
            r_acc  <= {{(AW - W - FRAC){bias[W-1]}}, bias, {FRAC{1'b0}}};
            r_idx  <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_out   <= w_sat;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode from state. in_ready is also gated by reset
  // so that it reads low while reset is held.
  always_comb begin
    in_ready    = (r_state == S_IDLE) && rst;
    out_valid   = (r_state == S_OUT);
    out         = r_out;
    o_dbg_state = r_state;
  end

endmodule
